// File: rtl/dcc_packet_sequencer_pkg.sv
// Shared constants and helpers for the DCC packet sequencer.
package dcc_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_PREAMBLE = 2'd0;
  localparam logic [1:0] ST_START    = 2'd1;
  localparam logic [1:0] ST_BYTE     = 2'd2;
  localparam logic [1:0] ST_STOP     = 2'd3;

  localparam int DEF_PREAMBLE_BITS = 14;

  // Largest data byte count any build of the sequencer can be configured for
  localparam int BYTES_LIM = 7;
  localparam int XOR_W     = BYTES_LIM * 8;

  // DCC idle packet: byte0 = FF, byte1 = 00, checksum FF
  localparam logic [15:0] DCC_IDLE_PKT = 16'h00FF;
  localparam logic [2:0]  DCC_IDLE_LEN = 3'd2;
  localparam logic [7:0]  DCC_IDLE_CHK = 8'hFF;

  // XOR of the first len bytes of data (byte i in [8i+7:8i])
  function automatic logic [7:0] byte_xor(input logic [XOR_W-1:0] data,
                                          input logic [2:0]       len);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < BYTES_LIM; i++) begin
      if (3'(i) < len) acc = acc ^ data[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/dcc_packet_sequencer_if.sv
// Host-side packet handshake of the DCC packet sequencer.
// valid/ready: a packet transfers in any cycle where pkt_valid & pkt_ready are both 1;
// pkt_len/pkt_data are only meaningful while pkt_valid is 1. pkt_err and pkt_done are
// single-cycle status pulses from the sequencer back to the host.
interface dcc_packet_sequencer_if #(
  parameter int MAX_BYTES = 5
);
  logic                   pkt_valid;
  logic                   pkt_ready;
  logic [2:0]             pkt_len;
  logic [MAX_BYTES*8-1:0] pkt_data;
  logic                   pkt_err;
  logic                   pkt_done;

  modport master (
    output pkt_valid, pkt_len, pkt_data,
    input  pkt_ready, pkt_err, pkt_done
  );

  modport slave (
    input  pkt_valid, pkt_len, pkt_data,
    output pkt_ready, pkt_err, pkt_done
  );
endinterface

// File: rtl/dcc_packet_sequencer_ack_edge_sync.sv
// Two-flop synchroniser for the encoder ack followed by a rising-edge pulse.
module ack_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);
  logic sync1, sync2, sync_prev;

  // Synchronise the ack and keep one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= async_in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // A held-high ack produces a single pulse
  assign pulse = sync2 & ~sync_prev;
endmodule

// File: rtl/dcc_packet_sequencer.sv
// Serialises DCC packets (preamble, start bits, bytes, checksum, end bit) for bit_encoder.
// One pending host slot; each host packet is sent REPEAT_CNT times; idle packets fill gaps.
module dcc_packet_sequencer
  import dcc_pkg::*;
#(
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int MAX_BYTES     = 5,
  parameter int REPEAT_CNT    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dcc_packet_sequencer_if.slave host,
  output logic                 tx_idle,
  input  logic                 enc_ack,
  output logic                 next_bit,
  output logic [1:0]           dbg_state
);
  localparam int DW = MAX_BYTES * 8;
  localparam int PW = $clog2(PREAMBLE_BITS + 1);
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);
  localparam logic [RW-1:0] REP_INIT = RW'(REPEAT_CNT);
  localparam logic [2:0]    LEN_MAX  = 3'(MAX_BYTES);

  logic          ack_evt;
  logic [1:0]    state;
  logic [PW-1:0] pre_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;

  logic          slot_full;
  logic [DW-1:0] slot_data;
  logic [2:0]    slot_len;

  logic [DW-1:0] act_data;
  logic [2:0]    act_len;
  logic [7:0]    act_chk;
  logic          act_idle;
  logic [RW-1:0] rep_left;

  logic          pkt_err_q, pkt_done_q;
  logic [7:0]    cur_byte;
  logic          take, len_ok, stop_evt, resend, select;

  ack_edge_sync u_ack_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (enc_ack),
    .pulse    (ack_evt)
  );

  assign take     = host.pkt_valid & ~slot_full;
  assign len_ok   = (host.pkt_len >= 3'd2) && (host.pkt_len <= LEN_MAX);
  assign stop_evt = ack_evt && (state == ST_STOP);
  assign resend   = stop_evt && !act_idle && (rep_left > RW'(1));
  assign select   = stop_evt && !resend;

  assign host.pkt_ready = ~slot_full;
  assign host.pkt_err   = pkt_err_q;
  assign host.pkt_done  = pkt_done_q;
  assign tx_idle        = act_idle;
  assign dbg_state      = state;

  // Byte currently on the wire: data bytes first, checksum after the last one
  always_comb begin
    cur_byte = act_chk;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if ((byte_idx == 3'(i)) && (byte_idx < act_len)) cur_byte = act_data[i*8 +: 8];
    end
  end

  // Bit presented to the encoder for the current state
  always_comb begin
    case (state)
      ST_START: next_bit = 1'b0;
      ST_BYTE:  next_bit = cur_byte[bit_idx];
      default:  next_bit = 1'b1;
    endcase
  end

  // Pending slot, active packet registers, repeat counter and status pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_full  <= 1'b0;
      slot_data  <= '0;
      slot_len   <= 3'd0;
      act_data   <= DW'(DCC_IDLE_PKT);
      act_len    <= DCC_IDLE_LEN;
      act_chk    <= DCC_IDLE_CHK;
      act_idle   <= 1'b1;
      rep_left   <= '0;
      pkt_err_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_err_q  <= take && !len_ok;
      pkt_done_q <= stop_evt && !act_idle && (rep_left == RW'(1));

      if (resend) rep_left <= rep_left - RW'(1);

      if (select) begin
        if (slot_full) begin
          act_data <= slot_data;
          act_len  <= slot_len;
          act_chk  <= byte_xor(XOR_W'(slot_data), slot_len);
          act_idle <= 1'b0;
          rep_left <= REP_INIT;
        end else begin
          act_data <= DW'(DCC_IDLE_PKT);
          act_len  <= DCC_IDLE_LEN;
          act_chk  <= DCC_IDLE_CHK;
          act_idle <= 1'b1;
        end
      end

      // take implies the slot is empty, so filling and freeing never coincide
      if (take && len_ok) begin
        slot_full <= 1'b1;
        slot_data <= host.pkt_data;
        slot_len  <= host.pkt_len;
      end else if (select && slot_full) begin
        slot_full <= 1'b0;
      end
    end
  end

  // Bit-level FSM, advancing once per encoder ack
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_PREAMBLE;
      pre_cnt  <= '0;
      bit_idx  <= 3'd7;
      byte_idx <= 3'd0;
    end else if (ack_evt) begin
      case (state)
        ST_PREAMBLE: begin
          if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            state   <= ST_START;
          end else begin
            pre_cnt <= pre_cnt + PW'(1);
          end
        end
        ST_START: begin
          state   <= ST_BYTE;
          bit_idx <= 3'd7;
        end
        ST_BYTE: begin
          if (bit_idx == 3'd0) begin
            if (byte_idx == act_len) begin
              state <= ST_STOP;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_START;
            end
          end else begin
            bit_idx <= bit_idx - 3'd1;
          end
        end
        default: begin
          state    <= ST_PREAMBLE;
          byte_idx <= 3'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcc_packet_sequencer.sv
// Bench for dcc_packet_sequencer: acts as the bit encoder and host, checks the bit
// stream against a packet-level model of the DCC sequence.
module tb_dcc_packet_sequencer;
  localparam int PB = 14;
  localparam int MB = 5;
  localparam int RC = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_ack = 1'b0;
  logic       tx_idle, next_bit;
  logic [1:0] dbg_state;

  dcc_packet_sequencer_if #(.MAX_BYTES(MB)) host ();

  dcc_packet_sequencer #(
    .PREAMBLE_BITS (PB),
    .MAX_BYTES     (MB),
    .REPEAT_CNT    (RC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .host      (host),
    .tx_idle   (tx_idle),
    .enc_ack   (enc_ack),
    .next_bit  (next_bit),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int err_seen  = 0;

  // Pulse counters
  always @(negedge clk) begin
    if (reset_n) begin
      if (host.pkt_done) done_seen++;
      if (host.pkt_err)  err_seen++;
    end
  end

  // Reference model: expected bit stream of the packet on the wire
  logic [0:0] exp_q[$];
  logic [7:0] m_cur[8];
  int         m_cur_len;
  bit         m_idle;
  int         m_rep;
  bit         m_slot_full;
  logic [7:0] m_slot[8];
  int         m_slot_len;
  int         exp_done = 0;
  int         exp_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_stream();
    logic [7:0] chk;
    chk = 8'h00;
    for (int i = 0; i < PB; i++) exp_q.push_back(1'b1);
    for (int b = 0; b < m_cur_len; b++) begin
      exp_q.push_back(1'b0);
      for (int k = 7; k >= 0; k--) exp_q.push_back(m_cur[b][k]);
      chk = chk ^ m_cur[b];
    end
    exp_q.push_back(1'b0);
    for (int k = 7; k >= 0; k--) exp_q.push_back(chk[k]);
    exp_q.push_back(1'b1);
  endtask

  task automatic m_set_idle();
    m_cur[0]  = 8'hFF;
    m_cur[1]  = 8'h00;
    m_cur_len = 2;
    m_idle    = 1'b1;
  endtask

  task automatic m_end_of_packet();
    if (!m_idle && m_rep > 1) begin
      m_rep--;
    end else begin
      if (!m_idle) exp_done++;
      if (m_slot_full) begin
        for (int i = 0; i < 8; i++) m_cur[i] = m_slot[i];
        m_cur_len   = m_slot_len;
        m_rep       = RC;
        m_idle      = 1'b0;
        m_slot_full = 1'b0;
      end else begin
        m_set_idle();
      end
    end
    load_stream();
  endtask

  task automatic m_reset();
    m_slot_full = 1'b0;
    m_rep = 0;
    m_set_idle();
    exp_q.delete();
    load_stream();
  endtask

  // driver: one encoder bit; sample, raise ack, hold, drop, and check settling
  task automatic send_bit(input int hold, input int low);
    bit stable;
    int k;
    @(negedge clk);
    check("next_bit", next_bit, exp_q[0]);
    check("tx_idle", tx_idle, m_idle);
    enc_ack = 1'b1;
    void'(exp_q.pop_front());
    if (exp_q.size() == 0) m_end_of_packet();
    stable = 1'b1;
    k = 0;
    for (int i = 0; i < hold + low; i++) begin
      @(negedge clk);
      k++;
      if (i == hold - 1) enc_ack = 1'b0;
      if (k >= 4 && next_bit !== exp_q[0]) stable = 1'b0;
    end
    check("bit_settled", stable, 1'b1);
  endtask

  task automatic run_bits(input int n, input int hold);
    for (int i = 0; i < n; i++) send_bit(hold, $urandom_range(3, 5));
  endtask

  task automatic run_until_idle(input int hold);
    int budget;
    budget = 3000;
    while (!(m_idle && !m_slot_full) && budget > 0) begin
      send_bit(hold, $urandom_range(3, 5));
      budget--;
    end
    check("drain_budget", budget > 0, 1'b1);
  endtask

  task automatic run_until_slot_free(input int hold);
    int budget;
    budget = 3000;
    while (m_slot_full && budget > 0) begin
      send_bit(hold, $urandom_range(3, 5));
      budget--;
    end
    check("select_budget", budget > 0, 1'b1);
  endtask

  // driver: offer one packet for a single cycle during a quiet part of a bit
  task automatic offer(input int len, input logic [MB*8-1:0] data);
    @(negedge clk);
    host.pkt_valid = 1'b1;
    host.pkt_len   = 3'(len);
    host.pkt_data  = data;
    #1;
    check("pkt_ready", host.pkt_ready, !m_slot_full);
    if (!m_slot_full) begin
      if (len >= 2 && len <= MB) begin
        m_slot_full = 1'b1;
        m_slot_len  = len;
        for (int i = 0; i < 8; i++) m_slot[i] = (i < MB) ? data[i*8 +: 8] : 8'h00;
      end else begin
        exp_err++;
      end
    end
    @(negedge clk);
    host.pkt_valid = 1'b0;
    host.pkt_len   = 3'($urandom);
    host.pkt_data  = {$urandom, $urandom};
    @(negedge clk);
    #1;
    check("err_count", err_seen, exp_err);
    check("ready_after", host.pkt_ready, !m_slot_full);
  endtask

  function automatic logic [MB*8-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    host.pkt_valid = 1'b0;
    host.pkt_len   = 3'd0;
    host.pkt_data  = '0;
    m_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_next_bit", next_bit, 1'b1);
    check("rst_pkt_ready", host.pkt_ready, 1'b1);
    check("rst_pkt_err", host.pkt_err, 1'b0);
    check("rst_pkt_done", host.pkt_done, 1'b0);
    check("rst_tx_idle", tx_idle, 1'b1);

    // idle stream with no host traffic
    run_bits(84, 1);
    check("idle_no_done", done_seen, 0);

    // packet 03,3F repeated three times, then idle
    offer(2, 40'h00_0000_3F03);
    run_until_idle(1);
    run_bits(42, 1);
    check("done_once", done_seen, exp_done);

    // rejected lengths
    offer(1, rand_data());
    offer(6, rand_data());
    check("err_two", err_seen, 2);
    run_bits(42, 1);

    // back-to-back packets, held ack, a third offer while the slot is full
    offer($urandom_range(2, MB), rand_data());
    run_until_slot_free(1);
    offer($urandom_range(2, MB), rand_data());
    offer($urandom_range(2, MB), rand_data());
    run_until_idle(8);
    check("done_b2b", done_seen, exp_done);

    // random lengths, random ack holds
    for (int r = 0; r < 4; r++) begin
      offer($urandom_range(0, 7), rand_data());
      run_until_idle(($urandom_range(0, 1) == 1) ? 8 : 1);
      check("done_rand", done_seen, exp_done);
    end

    // reset in the middle of a data byte with the slot full
    offer($urandom_range(2, MB), rand_data());
    run_until_slot_free(1);
    offer($urandom_range(2, MB), rand_data());
    run_bits(PB + 5, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    #1;
    check("mid_rst_next_bit", next_bit, 1'b1);
    check("mid_rst_ready", host.pkt_ready, 1'b1);
    check("mid_rst_tx_idle", tx_idle, 1'b1);
    run_bits(84, 1);
    check("done_after_rst", done_seen, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
